pass_slice: RTL and testbench
=============================

PASS_SLICE -- requirements
Module: pass_slice

Interface
REQ-001 Parameter WIDTH, default 16, bits per channel sample.
REQ-002 Parameter CHANNELS, default 2, channel count; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-003 Parameter CNT_W, default 16, width of the beat counter.
REQ-004 Sclk  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  synchronous, active-low reset, sampled on rising Sclk.
REQ-006 in_data  input  CHANNELS*WIDTH  upstream packed sample word.
REQ-007 in_valid  input  1  upstream word valid.
REQ-008 in_ready  output  1  slice can accept a word this cycle.
REQ-009 out_data  output  CHANNELS*WIDTH  downstream packed sample word.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 beat_cnt  output  CNT_W  count of completed output transfers.
REQ-013 swap  input  1  reverse channel order on capture; port exists only when PASS_SLICE_SWAP_EN is defined.

Function
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-015 Storage: main register (drives out_data) plus one skid register; no combinational path from in_* to out_*, or from out_ready to in_ready.
REQ-016 State machine EMPTY / ONE / TWO; out_valid = (state != EMPTY); in_ready = (state != TWO), both decoded from flops only.
REQ-017 EMPTY: in_valid -> main <= in_data, go ONE; else stay.
REQ-018 ONE: in_valid && out_ready -> main <= in_data, stay ONE; in_valid && !out_ready -> skid <= in_data, go TWO; !in_valid && out_ready -> go EMPTY; else hold.
REQ-019 TWO: out_ready -> main <= skid, go ONE; else hold; in_valid ignored (in_ready = 0).
REQ-020 Latency: word accepted in cycle N is on out_data with out_valid = 1 in cycle N+1 when the slice was EMPTY or draining.
REQ-021 Ordering: words leave in exactly the order accepted; none dropped or duplicated.
REQ-022 out_data stable while out_valid && !out_ready.
REQ-023 beat_cnt increments by 1 on every output transfer; wraps from 2^CNT_W-1 to 0 without flag.
REQ-024 Full throughput: with in_valid and out_ready held high, one word transfers per cycle in steady state.

Reset
REQ-025 Reset_n = 0 at a rising edge: state <= EMPTY, out_valid = 0, in_ready = 1, beat_cnt = 0, main and skid = 0.
REQ-026 Reset mid-operation discards any held words; no transfer counted in the reset cycle.
REQ-027 First transfer is possible in the first cycle after Reset_n returns high.

Configuration
REQ-028 Macro PASS_SLICE_SWAP_EN defined: swap port present; when swap = 1 at an input transfer, channel k of in_data is stored as channel CHANNELS-1-k; swap = 0 stores unchanged.
REQ-029 Macro PASS_SLICE_SWAP_EN undefined: swap port absent; words always stored unchanged; all other behaviour identical.

Verification
REQ-030 Reset: Reset_n = 0 for 2 cycles -> out_valid = 0, in_ready = 1, beat_cnt = 0, out_data = 0.
REQ-031 Streaming: WIDTH=16, CHANNELS=2, push 0x0001_0002..0x0008_0009 with out_ready = 1 -> same 8 words out in order, 1-cycle latency, beat_cnt = 8.
REQ-032 Backpressure: push A, B with out_ready = 0 -> state TWO, in_ready = 0, out_data = A held; raise out_ready -> A then B, no loss.
REQ-033 Wrap: CNT_W=3, 9 output transfers -> beat_cnt sequence ends 7, 0, 1.
REQ-034 Mid-reset: slice in TWO, assert Reset_n = 0 one cycle -> EMPTY, out_valid = 0, beat_cnt = 0; old words never appear.
REQ-035 Swap (macro on): swap = 1, in_data = 0xAAAA_5555 -> out_data = 0x5555_AAAA; macro off -> 0xAAAA_5555.

Source files
------------

// File: rtl/pass_slice.sv
// pass_slice: two-entry skid buffer (main + skid register) with an output beat counter.
// Optional channel reversal on capture when PASS_SLICE_SWAP_EN is defined.
module pass_slice #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16
) (
`ifdef PASS_SLICE_SWAP_EN
  input  logic                      swap,
`endif
  input  logic                      Sclk,
  input  logic                      Reset_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          beat_cnt
);
  localparam int DW = CHANNELS * WIDTH;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, next;
  logic [DW-1:0] main_q, skid_q, cap;
  logic load_main, load_skid, from_skid;
`ifdef PASS_SLICE_SWAP_EN
  logic [DW-1:0] rev;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_rev
    assign rev[k*WIDTH +: WIDTH] = in_data[(CHANNELS-1-k)*WIDTH +: WIDTH];
  end
  assign cap = swap ? rev : in_data;
`else
  assign cap = in_data;
`endif
  // Handshake outputs decode the state flops only, so no in->out or ready->ready path exists.
  assign out_valid = state != EMPTY;
  assign in_ready  = state != TWO;
  assign out_data  = main_q;
  always_comb begin
    next      = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    case (state)
      EMPTY: begin
        load_main = in_valid;
        next      = in_valid ? ONE : EMPTY;
      end
      ONE: begin
        load_main = in_valid && out_ready;
        load_skid = in_valid && !out_ready;
        next      = in_valid ? (out_ready ? ONE : TWO) : (out_ready ? EMPTY : ONE);
      end
      TWO: begin
        load_main = out_ready;
        from_skid = 1'b1;
        next      = out_ready ? ONE : TWO;
      end
      default: next = EMPTY;
    endcase
  end
  always_ff @(posedge Sclk) begin
    if (!Reset_n) begin
      state    <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= next;
      if (load_main) main_q <= from_skid ? skid_q : cap;
      if (load_skid) skid_q <= cap;
      if (out_valid && out_ready) beat_cnt <= beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pass_slice.sv
// tb_pass_slice: randomized and directed checks of pass_slice against a queue-based model.
module tb_pass_slice;
`ifdef PASS_SLICE_SWAP_EN
  localparam bit SWAP_ON = 1'b1;
`else
  localparam bit SWAP_ON = 1'b0;
`endif
  logic        Sclk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        swap = 1'b0;
  logic        in_ready, out_valid, w_ready, w_valid;
  logic [31:0] out_data, w_data;
  logic [15:0] beat_cnt;
  logic [2:0]  w_cnt;
  logic [31:0] q[$];
  int unsigned exp_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 Sclk = ~Sclk;

  pass_slice #(.WIDTH(16), .CHANNELS(2), .CNT_W(16)) dut (
`ifdef PASS_SLICE_SWAP_EN
    .swap(swap),
`endif
    .Sclk(Sclk), .Reset_n(Reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .beat_cnt(beat_cnt)
  );

  pass_slice #(.WIDTH(16), .CHANNELS(2), .CNT_W(3)) dut_w (
`ifdef PASS_SLICE_SWAP_EN
    .swap(swap),
`endif
    .Sclk(Sclk), .Reset_n(Reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(w_ready), .out_data(w_data), .out_valid(w_valid),
    .out_ready(out_ready), .beat_cnt(w_cnt)
  );

  // Model: a FIFO of capacity two; transfers decided from occupancy before the edge.
  task automatic tick();
    bit ov, ir;
    ov = q.size() > 0;
    ir = q.size() < 2;
    if (!Reset_n) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      if (ov && out_ready) begin
        void'(q.pop_front());
        exp_cnt++;
      end
      if (in_valid && ir)
        q.push_back((SWAP_ON && swap) ? {in_data[15:0], in_data[31:16]} : in_data);
    end
    @(posedge Sclk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    n_checks++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL reset beat_cnt got %0d want 0", beat_cnt); end
    n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset out_data got %h want 0", out_data); end
    n_checks++; if (w_cnt !== 3'd0) begin n_fail++; $display("FAIL reset w_cnt got %0d want 0", w_cnt); end
    Reset_n = 1'b1;
  endtask

  task automatic test_streaming();
    logic [31:0] w;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = 32'h0001_0002 + i * 32'h0001_0001;
      in_data = w; in_valid = 1'b1;
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_data !== w) begin n_fail++; $display("FAIL stream word %0d got %b/%h want 1/%h", i, out_valid, out_data, w); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (beat_cnt !== 16'd8) begin n_fail++; $display("FAIL stream beat_cnt got %0d want 8", beat_cnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream drain out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hA0A0_0A0A; tick();
    in_data = 32'hB0B0_0B0B; tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp full in_ready got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hA0A0_0A0A) begin n_fail++; $display("FAIL bp full out got %b/%h want 1/a0a00a0a", out_valid, out_data); end
    in_data = 32'hC0C0_0C0C; tick();
    n_checks++; if (out_data !== 32'hA0A0_0A0A || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp hold out_data got %h want a0a00a0a", out_data); end
    in_valid = 1'b0; out_ready = 1'b1; tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hB0B0_0B0B) begin n_fail++; $display("FAIL bp second got %b/%h want 1/b0b00b0b", out_valid, out_data); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || beat_cnt !== 16'd10) begin n_fail++; $display("FAIL bp drain got %b/%0d want 0/10", out_valid, beat_cnt); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h1111_2222; tick();
    in_data = 32'h3333_4444; tick();
    Reset_n = 1'b0; in_valid = 1'b0; tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst flags got %b/%b want 0/1", out_valid, in_ready); end
    n_checks++; if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst beat_cnt got %0d want 0", beat_cnt); end
    Reset_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h5A5A_6B6B; tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h5A5A_6B6B) begin n_fail++; $display("FAIL midrst first got %b/%h want 1/5a5a6b6b", out_valid, out_data); end
    in_valid = 1'b0; tick();
    n_checks++; if (out_valid !== 1'b0 || beat_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst after got %b/%0d want 0/1", out_valid, beat_cnt); end
  endtask

  task automatic test_wrap();
    Reset_n = 1'b0; in_valid = 1'b0; tick();
    Reset_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 9);
      in_data = $urandom;
      tick();
      n_checks++; if (w_cnt !== 3'(exp_cnt % 8)) begin n_fail++; $display("FAIL wrap step %0d w_cnt got %0d want %0d", i, w_cnt, exp_cnt % 8); end
    end
    n_checks++; if (w_cnt !== 3'd1 || beat_cnt !== 16'd9) begin n_fail++; $display("FAIL wrap end got %0d/%0d want 1/9", w_cnt, beat_cnt); end
  endtask

  task automatic test_swap();
    logic [31:0] e;
    e = SWAP_ON ? 32'h5555_AAAA : 32'hAAAA_5555;
    out_ready = 1'b1; in_valid = 1'b1; swap = 1'b1; in_data = 32'hAAAA_5555; tick();
    n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL swap on got %h want %h", out_data, e); end
    swap = 1'b0; in_data = 32'h1234_5678; tick();
    n_checks++; if (out_data !== 32'h1234_5678) begin n_fail++; $display("FAIL swap off got %h want 12345678", out_data); end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      swap = $urandom_range(0, 1);
      in_data = $urandom;
      tick();
      n_checks++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rand %0d flags got %b/%b want %b/%b", i, out_valid, in_ready, q.size() > 0, q.size() < 2); end
      if (q.size() > 0) begin
        n_checks++; if (out_data !== q[0]) begin n_fail++; $display("FAIL rand %0d out_data got %h want %h", i, out_data, q[0]); end
      end
      n_checks++; if (beat_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rand %0d beat_cnt got %0d want %0d", i, beat_cnt, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_mid_reset();
    test_wrap();
    test_swap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
